// File: rtl/vin_max10adc_seq.sv
// MAX10 ADC sequencer: one conversion in flight, channel-tag checked, results published as 32-bit words.
// Define VIN_MAX10ADC_SEQ_AVG_EN to average 2^OVS_SHIFT samples per channel before publishing.
module vin_max10adc_seq #(
  parameter int NUM_CH    = 8,
  parameter int FIRST_CH  = 1,
  parameter int TIMEOUT   = 1023,
  parameter int OVS_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 cmd_valid,
  output logic [4:0]           cmd_channel,
  output logic                 cmd_sop,
  output logic                 cmd_eop,
  input  logic                 cmd_ready,
  input  logic                 rsp_valid,
  input  logic [4:0]           rsp_channel,
  input  logic [11:0]          rsp_data,
  output logic [NUM_CH*32-1:0] adc_data,
  output logic                 sweep_done,
  output logic [15:0]          err_count
);
  localparam int              IDXW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CH - 1);
  localparam logic [4:0]      FIRST    = 5'(FIRST_CH);
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

  if (NUM_CH < 1 || NUM_CH > 16 || FIRST_CH + NUM_CH > 18 || TIMEOUT < 1 || TIMEOUT > 65535 ||
      OVS_SHIFT < 0 || OVS_SHIFT > 4) begin : g_param_chk
    $error("vin_max10adc_seq: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [15:0]             tmo_q, tmo_d;
  logic [15:0]             err_q, err_d;
  logic [NUM_CH-1:0][11:0] word_q, word_d;
  logic                    sweep_q, sweep_d;
  logic [4:0]              exp_ch;
  logic                    accept, timeout, err_inc;

  assign exp_ch  = FIRST + 5'(idx_q);
  assign accept  = (state_q == WAIT_RSP) && rsp_valid && (rsp_channel == exp_ch);
  // A response landing on the timeout cycle wins over the timeout.
  assign timeout = (state_q == WAIT_RSP) && !rsp_valid && (tmo_q == TMO_LAST);
  assign err_inc = (rsp_valid && !accept) || timeout;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      IDLE:  state_d = ISSUE;
      ISSUE: begin
        if (cmd_ready) begin
          state_d = WAIT_RSP;
          tmo_d   = '0;
        end
      end
      WAIT_RSP: begin
        tmo_d = tmo_q + 16'd1;
        if (rsp_valid || timeout) state_d = ISSUE;
        if (accept) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (err_inc && err_q != 16'hFFFF) err_d = err_q + 16'd1;
  end

`ifdef VIN_MAX10ADC_SEQ_AVG_EN
  localparam int            AW       = 12 + OVS_SHIFT;
  localparam int            PW       = OVS_SHIFT + 1;
  localparam logic [PW-1:0] PASS_MAX = PW'((1 << OVS_SHIFT) - 1);

  logic [NUM_CH-1:0][AW-1:0] acc_q, acc_d;
  logic [NUM_CH-1:0][PW-1:0] pass_q, pass_d;
  logic [AW-1:0]             sum;

  always_comb begin
    word_d  = word_q;
    sweep_d = 1'b0;
    acc_d   = acc_q;
    pass_d  = pass_q;
    sum     = acc_q[idx_q] + AW'(rsp_data);
    if (accept) begin
      if (pass_q[idx_q] == PASS_MAX) begin
        word_d[idx_q] = 12'(sum >> OVS_SHIFT);
        acc_d[idx_q]  = '0;
        pass_d[idx_q] = '0;
        sweep_d       = (idx_q == LAST_IDX);
      end else begin
        acc_d[idx_q]  = sum;
        pass_d[idx_q] = pass_q[idx_q] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      pass_q <= '0;
    end else begin
      acc_q  <= acc_d;
      pass_q <= pass_d;
    end
  end
`else
  always_comb begin
    word_d  = word_q;
    sweep_d = 1'b0;
    if (accept) begin
      word_d[idx_q] = rsp_data;
      sweep_d       = (idx_q == LAST_IDX);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      word_q  <= '0;
      sweep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      word_q  <= word_d;
      sweep_q <= sweep_d;
    end
  end

  assign cmd_valid   = (state_q == ISSUE);
  assign cmd_channel = exp_ch;
  assign cmd_sop     = cmd_valid;
  assign cmd_eop     = cmd_valid;
  assign sweep_done  = sweep_q;
  assign err_count   = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_word
    assign adc_data[32*g +: 32] = {20'b0, word_q[g]};
  end
endmodule

// File: tb/tb_vin_max10adc_seq.sv
// Bench for vin_max10adc_seq: transaction-level reference model plus directed scenarios.
module tb_vin_max10adc_seq;
  localparam int NUM_CH = 8, FIRST_CH = 1, TIMEOUT = 15, OVS_SHIFT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 cmd_valid, cmd_sop, cmd_eop;
  logic [4:0]           cmd_channel;
  logic                 cmd_ready = 1'b1;
  logic                 rsp_valid = 1'b0;
  logic [4:0]           rsp_channel = '0;
  logic [11:0]          rsp_data = '0;
  logic [NUM_CH*32-1:0] adc_data;
  logic                 sweep_done;
  logic [15:0]          err_count;

  vin_max10adc_seq #(.NUM_CH(NUM_CH), .FIRST_CH(FIRST_CH), .TIMEOUT(TIMEOUT), .OVS_SHIFT(OVS_SHIFT)) dut (
    .clk(clk), .reset(rst),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .adc_data(adc_data), .sweep_done(sweep_done), .err_count(err_count)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one outstanding conversion, sweep position, waiting time, error tally.
  int m_started, m_outstanding, m_pos, m_waited, m_err, m_sweep;
  int m_word[NUM_CH], m_sum[NUM_CH], m_cnt[NUM_CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started = 0; m_outstanding = 0; m_pos = 0; m_waited = 0; m_err = 0; m_sweep = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_word[i] = 0; m_sum[i] = 0; m_cnt[i] = 0; end
    end else begin
      m_sweep = 0;
      if (!m_started) begin
        m_started = 1;
        if (rsp_valid) m_err = (m_err < 65535) ? m_err + 1 : m_err;
      end else if (!m_outstanding) begin
        if (rsp_valid) m_err = (m_err < 65535) ? m_err + 1 : m_err;
        if (cmd_ready) begin m_outstanding = 1; m_waited = 0; end
      end else begin
        m_waited++;
        if (rsp_valid) begin
          m_outstanding = 0;
          if (int'(rsp_channel) == FIRST_CH + m_pos) begin
`ifdef VIN_MAX10ADC_SEQ_AVG_EN
            m_sum[m_pos] += int'(rsp_data);
            m_cnt[m_pos]++;
            if (m_cnt[m_pos] == (1 << OVS_SHIFT)) begin
              m_word[m_pos] = m_sum[m_pos] / (1 << OVS_SHIFT);
              m_sum[m_pos] = 0; m_cnt[m_pos] = 0;
              if (m_pos == NUM_CH - 1) m_sweep = 1;
            end
`else
            m_word[m_pos] = int'(rsp_data);
            if (m_pos == NUM_CH - 1) m_sweep = 1;
`endif
            m_pos = (m_pos + 1) % NUM_CH;
          end else m_err = (m_err < 65535) ? m_err + 1 : m_err;
        end else if (m_waited == TIMEOUT) begin
          m_outstanding = 0;
          m_err = (m_err < 65535) ? m_err + 1 : m_err;
        end
      end
    end
  end

  bit chk_en = 0;
  int sweeps_seen = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_valid", cmd_valid, (m_started && !m_outstanding) ? 1 : 0);
      chk("cmd_sop", cmd_sop, (m_started && !m_outstanding) ? 1 : 0);
      chk("cmd_eop", cmd_eop, (m_started && !m_outstanding) ? 1 : 0);
      chk("cmd_channel", cmd_channel, FIRST_CH + m_pos);
      chk("sweep_done", sweep_done, m_sweep);
      chk("err_count", err_count, m_err);
      for (int i = 0; i < NUM_CH; i++) chk($sformatf("adc_word%0d", i), adc_data[32*i +: 32], m_word[i]);
      if (sweep_done) sweeps_seen++;
    end
  end

  // ADC responder: answers each accepted command after a latency, with optional faults.
  int lat_dflt = 3, lat_once = 0, cnt = 0, bad_ch = -1, bad_tag = 0, hs_count = 0;
  bit drop_once = 0, fire = 0;
  logic [4:0]  pend_tag;
  logic [11:0] pend_dat;
  int hs_ch[$];
  logic [11:0] dq[$];

  always @(posedge clk) begin
    fire = 0;
    if (!rst && cmd_valid && cmd_ready) begin
      hs_count++;
      hs_ch.push_back(int'(cmd_channel));
      if (drop_once) drop_once = 0;
      else begin
        cnt = (lat_once > 0) ? lat_once : lat_dflt;
        lat_once = 0;
        pend_tag = cmd_channel;
        if (bad_ch == int'(cmd_channel)) begin pend_tag = 5'(bad_tag); bad_ch = -1; end
        if (cmd_channel == 5'd1 && dq.size() > 0) pend_dat = dq.pop_front();
        else pend_dat = 12'(12'h100 + cmd_channel);
      end
    end
    if (cnt > 0) begin cnt--; fire = (cnt == 0); end
    #1;
    rsp_valid   = fire;
    rsp_channel = fire ? pend_tag : 5'd0;
    rsp_data    = fire ? pend_dat : 12'd0;
  end

  int k, n, hs0;
  initial begin
    // Reset values.
    tick();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_channel", cmd_channel, FIRST_CH);
    chk("rst_sweep", sweep_done, 0);
    chk("rst_err", err_count, 0);
    for (int i = 0; i < NUM_CH; i++) chk("rst_word", adc_data[32*i +: 32], 0);
    chk_en = 1;
    rst = 1'b0;
    chk("rel_cmd_valid0", cmd_valid, 0);
    tick();
    chk("rel_cmd_valid1", cmd_valid, 1);

    // Four full sweeps with default responses.
    k = 0;
    while (hs_count < 33 && k < 3000) begin tick(); k++; end
    chk("t1_budget", (hs_count >= 33) ? 1 : 0, 1);
    for (int i = 0; i < 9; i++) chk("t1_ch_seq", hs_ch[i], (i % 8) + 1);
    for (int i = 0; i < NUM_CH; i++) chk("t1_word", adc_data[32*i +: 32], 32'h100 + i + 1);
`ifdef VIN_MAX10ADC_SEQ_AVG_EN
    chk("t1_sweeps", sweeps_seen, 1);
`else
    chk("t1_sweeps", sweeps_seen, 4);
`endif
    chk("t1_err", err_count, 0);

    // Command stall: ready low for 5 cycles while the command is held.
    cmd_ready = 1'b0;
    k = 0;
    while (cmd_valid !== 1'b1 && k < 50) begin tick(); k++; end
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", cmd_valid, 1);
      chk("t2_hold_ch", cmd_channel, 2);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    chk("t2_one_hs", hs_count, 34);
    tick();
    chk("t2_still_one", hs_count, 34);
    chk("t2_valid_low", cmd_valid, 0);

    // Wrong tag on channel 2.
    bad_ch = 2; bad_tag = 5;
    k = 0;
    while (bad_ch != -1 && k < 500) begin tick(); k++; end
    hs0 = hs_count;
    k = 0;
    while (hs_count == hs0 && k < 100) begin tick(); k++; end
    chk("t3_reissue_ch", hs_ch[hs_ch.size()-1], 2);
    chk("t3_err", err_count, 1);
    chk("t3_word1", adc_data[63:32], 32'h102);

    // Timeout with no response.
    drop_once = 1;
    k = 0;
    while (drop_once && k < 500) begin tick(); k++; end
    n = 0;
    while (cmd_valid === 1'b0 && n < 200) begin n++; tick(); end
    chk("t4_wait_cycles", n, TIMEOUT);
    chk("t4_err", err_count, 2);
    // Response on the timeout cycle is accepted, not counted as an error.
    lat_once = TIMEOUT;
    k = 0;
    while (lat_once != 0 && k < 100) begin tick(); k++; end
    repeat (20) tick();
    chk("t4_rsp_on_tmo_err", err_count, 2);

    // Asynchronous reset while waiting, then a late response.
    lat_once = 6;
    k = 0;
    while (lat_once != 0 && k < 100) begin tick(); k++; end
    cmd_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", cmd_valid, 0);
    chk("t5_async_ch", cmd_channel, FIRST_CH);
    chk("t5_async_err", err_count, 0);
    chk("t5_async_sweep", sweep_done, 0);
    for (int i = 0; i < NUM_CH; i++) chk("t5_async_word", adc_data[32*i +: 32], 0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) tick();
    chk("t5_late_err", err_count, 1);
    for (int i = 0; i < NUM_CH; i++) chk("t5_late_word", adc_data[32*i +: 32], 0);

    // Channel 1 samples 0xFFF x3 then 0xFFC.
    dq.push_back(12'hFFF); dq.push_back(12'hFFF); dq.push_back(12'hFFF); dq.push_back(12'hFFC);
    cmd_ready = 1'b1;
    k = 0;
    while (dq.size() > 1 && k < 1000) begin tick(); k++; end
    hs0 = hs_count;
    k = 0;
    while (hs_count == hs0 && k < 100) begin tick(); k++; end
`ifdef VIN_MAX10ADC_SEQ_AVG_EN
    chk("t6_word0_held", adc_data[31:0], 0);
`else
    chk("t6_word0_raw3", adc_data[31:0], 32'hFFF);
`endif
    k = 0;
    while (dq.size() > 0 && k < 1000) begin tick(); k++; end
    hs0 = hs_count;
    k = 0;
    while (hs_count == hs0 && k < 100) begin tick(); k++; end
`ifdef VIN_MAX10ADC_SEQ_AVG_EN
    chk("t6_word0_avg", adc_data[31:0], 32'hFFE);
`else
    chk("t6_word0_raw4", adc_data[31:0], 32'hFFC);
`endif
    chk("t6_err", err_count, 1);

    repeat (3) tick();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
